// File: rtl/div_mul_unit_pkg.sv
// Shared CPU constants for the multiply/divide unit: opcode bit indices,
// HI/LO move indices, FSM state encoding and a one-hot check helper.
package div_mul_unit_pkg;

  // div_mul_control bit positions
  localparam int unsigned OP_W     = 4;
  localparam int unsigned OP_DIV   = 0;
  localparam int unsigned OP_DIVU  = 1;
  localparam int unsigned OP_MULT  = 2;
  localparam int unsigned OP_MULTU = 3;

  // hi_lo_control bit positions
  localparam int unsigned HL_W    = 2;
  localparam int unsigned HL_MTHI = 0;
  localparam int unsigned HL_MTLO = 1;

  // FSM state encoding
  localparam int unsigned ST_W    = 2;
  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_CALC = 2'd1;
  localparam logic [1:0]  ST_DONE = 2'd2;

  // True when exactly one opcode bit is set
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/div_mul_datapath.sv
// Multiply/divide datapath: latches operand magnitudes and signs, runs one
// radix-2 shift-add (multiply) or restoring-subtract (divide) step per
// cycle on a shared 2*DATA_W accumulator, and sign-fixes the result.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   load              accept a new operation (op, src1, src2 sampled)
//   step              perform one iteration
//   op                one-hot opcode (div, divu, mult, multu)
//   src1, src2        raw operands
//   res_hi_c/res_lo_c sign-fixed result for HI/LO (combinational)
module div_mul_datapath
  import div_mul_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic [DATA_W-1:0] res_hi_c,
  output logic [DATA_W-1:0] res_lo_c
);

  localparam int unsigned ACC_W = 2 * DATA_W;
  localparam int unsigned REM_W = DATA_W + 1;

  logic              mul_q;
  logic              neg_q;
  logic              neg_rem_q;
  logic              div0_q;
  logic [DATA_W-1:0] b_q;
  logic [ACC_W-1:0]  acc_q;

  logic              signed_op;
  logic              mul_op;
  logic              s1;
  logic              s2;
  logic [DATA_W-1:0] m1;
  logic [DATA_W-1:0] m2;
  logic [REM_W-1:0]  mul_sum;
  logic [REM_W-1:0]  div_trial;
  logic [ACC_W-1:0]  acc_next;
  logic [ACC_W-1:0]  prod_fix;
  logic [DATA_W-1:0] quot;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quot_fix;
  logic [DATA_W-1:0] rem_fix;

  // Operand decode; the opcode is one-hot whenever load is asserted
  always_comb begin
    signed_op = !(op[OP_DIVU] | op[OP_MULTU]);
    mul_op    = op[OP_MULT] | op[OP_MULTU];
    s1        = signed_op & src1[DATA_W-1];
    s2        = signed_op & src2[DATA_W-1];
    m1        = s1 ? (~src1 + DATA_W'(1)) : src1;
    m2        = s2 ? (~src2 + DATA_W'(1)) : src2;
  end

  // One iteration. Multiply: add multiplicand into the upper half when the
  // current multiplier LSB is set, then shift right with the carry.
  // Divide: trial-subtract the divisor from the shifted partial remainder
  // (DATA_W+1 bits), keep it on no borrow and shift in the quotient bit.
  always_comb begin
    mul_sum   = {1'b0, acc_q[ACC_W-1:DATA_W]} + (acc_q[0] ? {1'b0, b_q} : REM_W'(0));
    div_trial = acc_q[ACC_W-1:DATA_W-1] - {1'b0, b_q};
    if (mul_q) begin
      acc_next = {mul_sum, acc_q[DATA_W-1:1]};
    end else if (div_trial[DATA_W]) begin
      acc_next = {acc_q[ACC_W-2:0], 1'b0};
    end else begin
      acc_next = {div_trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
    end
  end

  // Operand/accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      b_q       <= '0;
      acc_q     <= '0;
    end else if (load) begin
      mul_q     <= mul_op;
      neg_q     <= s1 ^ s2;
      neg_rem_q <= s1;
      div0_q    <= !mul_op && (src2 == '0);
      b_q       <= mul_op ? m1 : m2;
      acc_q     <= {DATA_W'(0), (mul_op ? m2 : m1)};
    end else if (step) begin
      acc_q     <= acc_next;
    end
  end

  // Sign fix. A zero divisor leaves the dividend magnitude as remainder,
  // which sign-fixes back to src1; only the quotient is forced to all ones.
  always_comb begin
    prod_fix = neg_q ? (~acc_q + ACC_W'(1)) : acc_q;
    quot     = acc_q[DATA_W-1:0];
    rem      = acc_q[ACC_W-1:DATA_W];
    quot_fix = div0_q ? '1 : (neg_q ? (~quot + DATA_W'(1)) : quot);
    rem_fix  = neg_rem_q ? (~rem + DATA_W'(1)) : rem;
    res_hi_c = mul_q ? prod_fix[ACC_W-1:DATA_W] : rem_fix;
    res_lo_c = mul_q ? prod_fix[DATA_W-1:0] : quot_fix;
  end

endmodule

// File: rtl/div_mul_unit.sv
// Iterative multiply/divide unit with the architectural HI/LO registers.
// Ports:
//   clk, resetn      clock, async active-low reset
//   op_valid         issue strobe for div_mul_control
//   div_mul_control  one-hot: [0] div, [1] divu, [2] mult, [3] multu
//   src1, src2       dividend/multiplicand, divisor/multiplier
//   hi_lo_control    [0] mthi, [1] mtlo
//   hi_lo_wdata      mthi/mtlo data
//   busy             operation in progress (combinational from state)
//   done             one-cycle pulse in the commit cycle
//   hi, lo           HI/LO registers
module div_mul_unit
  import div_mul_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              op_valid,
  input  logic [OP_W-1:0]   div_mul_control,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [HL_W-1:0]   hi_lo_control,
  input  logic [DATA_W-1:0] hi_lo_wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic [ST_W-1:0]   state_q;
  logic [ST_W-1:0]   state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] hi_d;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] lo_d;
  logic              done_q;
  logic              done_d;
  logic              accept;
  logic              calc_step;
  logic [DATA_W-1:0] res_hi_c;
  logic [DATA_W-1:0] res_lo_c;

  assign accept    = (state_q == ST_IDLE) && op_valid && is_onehot4(div_mul_control);
  assign calc_step = (state_q == ST_CALC);

  div_mul_datapath #(
    .DATA_W (DATA_W)
  ) u_datapath (
    .clk      (clk),
    .rst_n    (resetn),
    .load     (accept),
    .step     (calc_step),
    .op       (div_mul_control),
    .src1     (src1),
    .src2     (src2),
    .res_hi_c (res_hi_c),
    .res_lo_c (res_lo_c)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Next state; mthi/mtlo apply in any state but the commit overrides them
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (hi_lo_control[HL_MTHI]) hi_d = hi_lo_wdata;
    if (hi_lo_control[HL_MTLO]) lo_d = hi_lo_wdata;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_CALC;
          cnt_d   = '0;
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        hi_d    = res_hi_c;
        lo_d    = res_lo_c;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_div_mul_unit.sv
// Self-checking bench for div_mul_unit: directed cases plus randomized
// operations checked against an arithmetic reference model.
module tb_div_mul_unit;

  localparam logic [3:0] C_DIV   = 4'b0001;
  localparam logic [3:0] C_DIVU  = 4'b0010;
  localparam logic [3:0] C_MULT  = 4'b0100;
  localparam logic [3:0] C_MULTU = 4'b1000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [3:0]  div_mul_control;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [1:0]  hi_lo_control;
  logic [31:0] hi_lo_wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned t0 = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  div_mul_unit dut (
    .clk             (clk),
    .resetn          (resetn),
    .op_valid        (op_valid),
    .div_mul_control (div_mul_control),
    .src1            (src1),
    .src2            (src2),
    .hi_lo_control   (hi_lo_control),
    .hi_lo_wdata     (hi_lo_wdata),
    .busy            (busy),
    .done            (done),
    .hi              (hi),
    .lo              (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  // Reference: plain arithmetic, returns {hi, lo}
  function automatic logic [63:0] model(input logic [3:0] code, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa;
    longint sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (code)
      C_MULTU: r = 64'(a) * 64'(b);
      C_MULT:  r = 64'(sa * sb);
      C_DIVU:  r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      C_DIV:   r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic issue(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_valid        = 1'b1;
    div_mul_control = code;
    src1            = a;
    src2            = b;
    @(posedge clk);
    #1;
    t0              = cyc;
    op_valid        = 1'b0;
    div_mul_control = 4'b0;
    src1            = $urandom;
    src2            = $urandom;
  endtask

  task automatic finish_op(input string tag, input logic [63:0] expv);
    int dones = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (!busy) break;
    end
    exp_hi = expv[63:32];
    exp_lo = expv[31:0];
    check({tag, "_latency"}, 32'(cyc - t0), 32'd33);
    check({tag, "_done_pulses"}, 32'(dones), 32'd1);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  task automatic run_op(input string tag, input logic [3:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] expv);
    issue(code, a, b);
    finish_op(tag, expv);
  endtask

  initial begin
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;

    resetn          = 1'b0;
    op_valid        = 1'b0;
    div_mul_control = 4'b0;
    src1            = '0;
    src2            = '0;
    hi_lo_control   = 2'b0;
    hi_lo_wdata     = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    resetn = 1'b1;

    // Directed cases with hand-derived results
    run_op("multu_max", C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg", C_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("divu_100_7", C_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
    run_op("div_neg7_2", C_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_ovf", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    run_op("divu_zero", C_DIVU, 32'h1234_5678, 32'd0, 64'h1234_5678_FFFF_FFFF);
    run_op("div_zero", C_DIV, 32'h1234_5678, 32'd0, 64'h1234_5678_FFFF_FFFF);
    run_op("div_zero_neg", C_DIV, 32'h8765_4321, 32'd0, 64'h8765_4321_FFFF_FFFF);

    // mthi in IDLE touches only HI
    @(negedge clk);
    hi_lo_control = 2'b01;
    hi_lo_wdata   = 32'hAAAA_0000;
    @(posedge clk);
    #1;
    hi_lo_control = 2'b00;
    exp_hi        = 32'hAAAA_0000;
    check("mthi_hi", hi, exp_hi);
    check("mthi_lo", lo, exp_lo);

    // Illegal multi-hot opcode and empty opcode in IDLE are ignored
    @(negedge clk);
    op_valid        = 1'b1;
    div_mul_control = 4'b0101;
    @(negedge clk);
    check("multihot_busy", 32'(busy), 32'd0);
    div_mul_control = 4'b0000;
    @(negedge clk);
    check("nohot_busy", 32'(busy), 32'd0);
    op_valid = 1'b0;
    check("ignored_hi", hi, exp_hi);
    check("ignored_lo", lo, exp_lo);

    // mtlo mid-CALC sticks until commit; a stray issue during CALC is ignored
    issue(C_MULTU, 32'd2, 32'd3);
    repeat (9) @(negedge clk);
    hi_lo_control = 2'b10;
    hi_lo_wdata   = 32'h0000_5555;
    @(posedge clk);
    #1;
    hi_lo_control = 2'b00;
    check("mtlo_calc_lo", lo, 32'h0000_5555);
    check("mtlo_calc_busy", 32'(busy), 32'd1);
    @(negedge clk);
    op_valid        = 1'b1;
    div_mul_control = C_DIV;
    src1            = 32'd100;
    src2            = 32'd7;
    @(posedge clk);
    #1;
    op_valid        = 1'b0;
    div_mul_control = 4'b0;
    finish_op("mtlo_then_multu", 64'd6);

    // mthi during the commit cycle loses to the completion write
    issue(C_MULTU, 32'd9, 32'd9);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
    end
    hi_lo_control = 2'b11;
    hi_lo_wdata   = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    hi_lo_control = 2'b00;
    check("done_mt_hi", hi, 32'd0);
    check("done_mt_lo", lo, 32'd81);

    // Async reset in the middle of a divide
    issue(C_DIV, 32'h1234_5678, 32'd3);
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_hi", hi, 32'd0);
    check("midreset_lo", lo, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_op("after_reset_multu", C_MULTU, 32'd7, 32'd6, 64'd42);

    // Randomized operations against the reference model
    for (int n = 0; n < 24; n++) begin
      code = 4'b0001 << $urandom_range(0, 3);
      a    = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 20));
        default: b = 32'($urandom);
      endcase
      run_op($sformatf("rand%0d_op%h", n, code), code, a, b, model(code, a, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
